// File: rtl/uart_cmd_matcher.sv
// rtl/uart_cmd_matcher.sv - pops fixed-length RX frames, masks-and-compares them, replies OK/ER on TX
// Pulses pass/fail/timeout, keeps a saturating match count and throttles RX pops to one every 2 cycles.
module uart_cmd_matcher #(
  parameter int unsigned                 CMD_LENGTH     = 4,
  parameter logic [8*CMD_LENGTH-1:0]     MATCH_PATTERN  = 32'h54455354,
  parameter logic [8*CMD_LENGTH-1:0]     MATCH_MASK     = '1,
  parameter int unsigned                 TIMEOUT_CYCLES = 2700000,
  parameter bit                          REPLY_EN       = 1'b1,
  parameter int unsigned                 COUNT_WIDTH    = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   rx_fifo_empty_i,
  input  logic [7:0]             rx_fifo_data_out_i,
  output logic                   rx_fifo_read_en_o,
  input  logic                   tx_fifo_full_i,
  output logic [7:0]             tx_fifo_data_in_o,
  output logic                   tx_fifo_write_en_o,
  output logic                   cmd_pass_o,
  output logic                   cmd_fail_o,
  output logic                   cmd_timeout_o,
  output logic [COUNT_WIDTH-1:0] pass_count_o,
  output logic                   busy_o
);

  localparam int unsigned IDX_W = (CMD_LENGTH > 1) ? $clog2(CMD_LENGTH) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_LENGTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPARE = 2'd1,
    REPLY   = 2'd2
  } state_e;

  state_e                        state_q;
  logic [IDX_W-1:0]              idx_q;
  logic [TO_W-1:0]               to_cnt_q;
  logic [CMD_LENGTH-1:0][7:0]    frame_q;
  logic                          match_q;
  logic [2:0]                    ptr_q;
  logic                          rd_q;
  logic                          wr_q;
  logic [7:0]                    wdata_q;
  logic                          pass_q;
  logic                          fail_q;
  logic                          to_q;
  logic [COUNT_WIDTH-1:0]        cnt_q;
  logic                          busy_q;

  logic       pop;
  logic       match;
  logic       expire;
  logic       reply_sel;
  logic [7:0] reply_byte;

  // The rd_q cooldown hides the FIFO's one-cycle empty-flag lag after a pop.
  assign pop    = (state_q == COLLECT) && !rx_fifo_empty_i && !rd_q;
  assign match  = ((frame_q ^ MATCH_PATTERN) & MATCH_MASK) == '0;
  assign expire = (TIMEOUT_CYCLES != 0) && (state_q == COLLECT) && (idx_q != '0)
                  && !pop && (to_cnt_q == TO_LAST);

  // COMPARE already issues the first reply byte, so it must use the live result.
  assign reply_sel = (state_q == COMPARE) ? match : match_q;

  always_comb begin
    reply_byte = 8'h0A;
    case (ptr_q[1:0])
      2'd0:    reply_byte = reply_sel ? 8'h4F : 8'h45;
      2'd1:    reply_byte = reply_sel ? 8'h4B : 8'h52;
      2'd2:    reply_byte = 8'h0D;
      default: reply_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= COLLECT;
      idx_q    <= '0;
      to_cnt_q <= '0;
      frame_q  <= '0;
      match_q  <= 1'b0;
      ptr_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      to_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      to_q   <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (pop) begin
            rd_q                      <= 1'b1;
            frame_q[IDX_LAST - idx_q] <= rx_fifo_data_out_i;
            to_cnt_q                  <= '0;
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= COMPARE;
              busy_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else if (expire) begin
            idx_q    <= '0;
            to_cnt_q <= '0;
            to_q     <= 1'b1;
          end else if ((idx_q != '0) && (TIMEOUT_CYCLES != 0)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end else begin
            to_cnt_q <= '0;
          end
        end
        COMPARE: begin
          pass_q  <= match;
          fail_q  <= !match;
          match_q <= match;
          ptr_q   <= '0;
          if (match && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (REPLY_EN) begin
            state_q <= REPLY;
            if (!tx_fifo_full_i) begin
              wr_q    <= 1'b1;
              wdata_q <= reply_byte;
              ptr_q   <= 3'd1;
            end
          end else begin
            state_q <= COLLECT;
            busy_q  <= 1'b0;
          end
        end
        REPLY: begin
          if (ptr_q == 3'd4) begin
            state_q <= COLLECT;
            busy_q  <= 1'b0;
          end else if (!tx_fifo_full_i) begin
            wr_q    <= 1'b1;
            wdata_q <= reply_byte;
            ptr_q   <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= COLLECT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_fifo_read_en_o  = rd_q;
  assign tx_fifo_write_en_o = wr_q;
  assign tx_fifo_data_in_o  = wdata_q;
  assign cmd_pass_o         = pass_q;
  assign cmd_fail_o         = fail_q;
  assign cmd_timeout_o      = to_q;
  assign pass_count_o       = cnt_q;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_uart_cmd_matcher.sv
// tb/tb_uart_cmd_matcher.sv - randomized self-checking bench for uart_cmd_matcher
// RX/TX FIFOs are modelled with queues; expected outcomes come from a frame-level reference model.
module tb_uart_cmd_matcher;

  localparam logic [31:0] PATTERN = 32'h54455354;
  localparam logic [31:0] MASK    = 32'hFFDFFFFF;
  localparam int          TIMEOUT = 100;
  localparam int          CW      = 8;
  localparam int          BUDGET  = 8000;
  localparam int          EV_PASS = 1;
  localparam int          EV_FAIL = 2;
  localparam int          EV_TO   = 3;

  logic          clock_i            = 1'b0;
  logic          reset_n_i          = 1'b1;
  logic          rx_fifo_empty_i    = 1'b1;
  logic [7:0]    rx_fifo_data_out_i = 8'h00;
  logic          tx_fifo_full_i     = 1'b0;
  logic          rx_fifo_read_en_o;
  logic [7:0]    tx_fifo_data_in_o;
  logic          tx_fifo_write_en_o;
  logic          cmd_pass_o;
  logic          cmd_fail_o;
  logic          cmd_timeout_o;
  logic [CW-1:0] pass_count_o;
  logic          busy_o;

  uart_cmd_matcher #(
    .CMD_LENGTH     (4),
    .MATCH_PATTERN  (PATTERN),
    .MATCH_MASK     (MASK),
    .TIMEOUT_CYCLES (TIMEOUT),
    .REPLY_EN       (1'b1),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clock_i            (clock_i),
    .reset_n_i          (reset_n_i),
    .rx_fifo_empty_i    (rx_fifo_empty_i),
    .rx_fifo_data_out_i (rx_fifo_data_out_i),
    .rx_fifo_read_en_o  (rx_fifo_read_en_o),
    .tx_fifo_full_i     (tx_fifo_full_i),
    .tx_fifo_data_in_o  (tx_fifo_data_in_o),
    .tx_fifo_write_en_o (tx_fifo_write_en_o),
    .cmd_pass_o         (cmd_pass_o),
    .cmd_fail_o         (cmd_fail_o),
    .cmd_timeout_o      (cmd_timeout_o),
    .pass_count_o       (pass_count_o),
    .busy_o             (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int         n_checks;
  int         n_errors;
  int         cyc;
  logic [7:0] rx_q[$];
  int         exp_ev[$];
  int         obs_ev[$];
  int         ev_cyc[$];
  logic [7:0] exp_tx[$];
  logic [7:0] obs_tx[$];
  int         tx_cyc[$];
  int         exp_cnt;
  int         viol_pop;
  int         viol_full;
  int         last_rd_cyc;
  int         busy_rise_cyc;
  int         busy_fall_cyc;
  bit         prev_rd;
  bit         prev_full;
  bit         prev_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh_rx();
    rx_fifo_empty_i    = (rx_q.size() == 0);
    rx_fifo_data_out_i = rx_fifo_empty_i ? 8'h00 : rx_q[0];
  endtask

  // Sample outputs mid-cycle, then let the RX FIFO honour the pop strobe just after the edge.
  task automatic cycle();
    bit do_pop;
    @(negedge clock_i);
    if (rx_fifo_read_en_o) begin
      if (prev_rd || prev_busy || rx_q.size() == 0) viol_pop++;
      last_rd_cyc = cyc;
    end
    if (tx_fifo_write_en_o) begin
      if (prev_full) viol_full++;
      obs_tx.push_back(tx_fifo_data_in_o);
      tx_cyc.push_back(cyc);
    end
    if (cmd_pass_o)    begin obs_ev.push_back(EV_PASS); ev_cyc.push_back(cyc); end
    if (cmd_fail_o)    begin obs_ev.push_back(EV_FAIL); ev_cyc.push_back(cyc); end
    if (cmd_timeout_o) begin obs_ev.push_back(EV_TO);   ev_cyc.push_back(cyc); end
    if (busy_o && !prev_busy) busy_rise_cyc = cyc;
    if (!busy_o && prev_busy) busy_fall_cyc = cyc;
    prev_rd   = rx_fifo_read_en_o;
    prev_full = tx_fifo_full_i;
    prev_busy = busy_o;
    do_pop    = rx_fifo_read_en_o;
    @(posedge clock_i);
    #1;
    cyc++;
    if (do_pop && rx_q.size() > 0) void'(rx_q.pop_front());
    refresh_rx();
  endtask

  task automatic expect_frame(input logic [31:0] f);
    bit m;
    m = ((f ^ PATTERN) & MASK) == 32'h0;
    exp_ev.push_back(m ? EV_PASS : EV_FAIL);
    if (m && exp_cnt < (1 << CW) - 1) exp_cnt++;
    if (m) begin
      exp_tx.push_back(8'h4F); exp_tx.push_back(8'h4B);
    end else begin
      exp_tx.push_back(8'h45); exp_tx.push_back(8'h52);
    end
    exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
  endtask

  task automatic push_frame(input logic [31:0] f);
    for (int b = 3; b >= 0; b--) rx_q.push_back(f[8*b +: 8]);
    refresh_rx();
    expect_frame(f);
  endtask

  task automatic feed_slow(input logic [31:0] f);
    for (int b = 3; b >= 0; b--) begin
      rx_q.push_back(f[8*b +: 8]);
      refresh_rx();
      repeat ($urandom_range(0, 60)) cycle();
    end
    expect_frame(f);
  endtask

  task automatic clear_model();
    exp_ev.delete(); obs_ev.delete(); ev_cyc.delete();
    exp_tx.delete(); obs_tx.delete(); tx_cyc.delete();
    viol_pop  = 0;
    viol_full = 0;
  endtask

  task automatic drain(input string tag, input bit rand_full);
    int n;
    n = 0;
    while (n < BUDGET && (rx_q.size() > 0 || obs_ev.size() < exp_ev.size()
                          || obs_tx.size() < exp_tx.size() || busy_o)) begin
      if (rand_full) tx_fifo_full_i = ($urandom_range(0, 3) == 0);
      cycle();
      n++;
    end
    tx_fifo_full_i = 1'b0;
    repeat (4) cycle();
    check({tag, " settled"}, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic compare(input string tag);
    int e0;
    check({tag, " event count"}, 32'(obs_ev.size()), 32'(exp_ev.size()));
    e0 = n_errors;
    foreach (exp_ev[i])
      if (i < obs_ev.size() && n_errors == e0) check({tag, " event"}, obs_ev[i], exp_ev[i]);
    check({tag, " tx count"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
    e0 = n_errors;
    foreach (exp_tx[i])
      if (i < obs_tx.size() && n_errors == e0) check({tag, " tx byte"}, 32'(obs_tx[i]), 32'(exp_tx[i]));
    check({tag, " pass_count"}, 32'(pass_count_o), exp_cnt);
    check({tag, " pop spacing"}, viol_pop, 0);
    check({tag, " write while full"}, viol_full, 0);
    clear_model();
  endtask

  task automatic do_reset(input string tag);
    reset_n_i = 1'b0;
    #1;
    check({tag, " outputs"}, 32'({rx_fifo_read_en_o, tx_fifo_write_en_o, tx_fifo_data_in_o, cmd_pass_o,
                                  cmd_fail_o, cmd_timeout_o, pass_count_o, busy_o}), 32'd0);
    clear_model();
    exp_cnt = 0;
    repeat (2) cycle();
    reset_n_i = 1'b1;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] f;
    int          n;
    int          b;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    exp_cnt  = 0;
    clear_model();
    refresh_rx();
    #2 reset_n_i = 1'b0;
    repeat (3) cycle();
    check("reset outputs", 32'({rx_fifo_read_en_o, tx_fifo_write_en_o, tx_fifo_data_in_o, cmd_pass_o,
                                cmd_fail_o, cmd_timeout_o, pass_count_o, busy_o}), 32'd0);
    reset_n_i = 1'b1;
    repeat (2) cycle();

    push_frame(PATTERN);
    drain("test", 1'b0);
    if (ev_cyc.size() == 1 && tx_cyc.size() == 4) begin
      check("pass latency", ev_cyc[0] - last_rd_cyc, 1);
      check("busy rise", busy_rise_cyc, last_rd_cyc);
      check("first write", tx_cyc[0], ev_cyc[0]);
      check("last write", tx_cyc[3], ev_cyc[0] + 3);
      check("busy fall", busy_fall_cyc, ev_cyc[0] + 4);
    end else begin
      check("timing stamps", 32'(ev_cyc.size() * 10 + tx_cyc.size()), 32'd14);
    end
    compare("test");

    push_frame(32'h54457354);
    drain("tesT", 1'b0);
    compare("tesT");

    rx_q.push_back(8'h54); rx_q.push_back(8'h45);
    refresh_rx();
    exp_ev.push_back(EV_TO);
    drain("timeout", 1'b0);
    if (ev_cyc.size() > 0) check("timeout latency", ev_cyc[0] - last_rd_cyc, TIMEOUT);
    else                   check("timeout seen", 32'(ev_cyc.size()), 32'd1);
    compare("timeout");
    push_frame(PATTERN);
    drain("after timeout", 1'b0);
    compare("after timeout");

    push_frame(PATTERN);
    n = 0;
    while (obs_tx.size() == 0 && n < 50) begin cycle(); n++; end
    check("bp first write", 32'(obs_tx.size()), 32'd1);
    tx_fifo_full_i = 1'b1;
    push_frame(PATTERN);
    push_frame($urandom);
    repeat (10) cycle();
    tx_fifo_full_i = 1'b0;
    drain("backpressure", 1'b0);
    compare("backpressure");

    push_frame(32'h54655354);
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0: f = PATTERN ^ (32'($urandom) & ~MASK);
        1: begin
          b = $urandom_range(0, 31);
          if (b == 21) b = 20;
          f = PATTERN ^ (32'h1 << b);
        end
        default: f = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) feed_slow(f);
      else                           push_frame(f);
    end
    drain("random", 1'b1);
    compare("random");

    for (int k = 0; k < 256; k++) push_frame(PATTERN ^ (32'($urandom) & ~MASK));
    drain("saturate", 1'b0);
    compare("saturate");

    rx_q.push_back(8'h54); rx_q.push_back(8'h45); rx_q.push_back(8'h53);
    refresh_rx();
    n = 0;
    while (rx_q.size() > 0 && n < 50) begin cycle(); n++; end
    repeat (2) cycle();
    do_reset("reset mid-frame");
    push_frame(PATTERN);
    drain("after frame reset", 1'b0);
    compare("after frame reset");

    push_frame(PATTERN);
    n = 0;
    while (obs_tx.size() == 0 && n < 50) begin cycle(); n++; end
    do_reset("reset mid-reply");
    push_frame(PATTERN);
    drain("after reply reset", 1'b0);
    compare("after reply reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
